i2c_cmd_seq: RTL and testbench
==============================

# i2c_cmd_seq

Command sequencer sitting directly upstream of the I2C master (`mod_I2C`). It accepts byte-transfer requests from the host logic into a small FIFO and drives the master's `command`/`address`/`data` inputs one transaction at a time. It completes the accept/busy handshake on the master's `ready` output and flags a stalled bus with a timeout. It owns no bus pins; SDA/SCL stay inside the master.

## Interface
- `DEPTH`, default 4: request FIFO depth; must be a power of two, at least 2.
- `TIMEOUT`, default 1023: maximum cycles spent in ISSUE or WAIT_DONE before an abort.
- `CMD_WRITE`, default 4'd1: command code for a write.
- `CMD_READ`, default 4'd2: command code for a read.
- `clk`  in  1: single clock; everything is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: host request strobe.
- `req_ready`  out  1: FIFO not full; a push occurs when `req_valid & req_ready` at a clock edge.
- `req_rw`  in  1: 0 = write, 1 = read.
- `req_addr`  in  8: I2C address byte.
- `req_data`  in  8: data byte; ignored for reads but still stored.
- `command`  out  4: to master; 0 = no-op.
- `address`  out  8: to master.
- `data`  out  8: to master.
- `ready`  in  1: from master; 1 = idle, 0 = transaction in progress.
- `busy`  out  1: FSM is not in IDLE.
- `done`  out  1: one-cycle pulse when a transaction completes.
- `err`  out  1: one-cycle pulse on a timeout abort.
- `fifo_count`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO**
  - Circular buffer, DEPTH entries of 17 bits: {rw, addr, data}.
  - Read and write pointers wrap modulo DEPTH.
  - `req_ready = (fifo_count != DEPTH)`, derived from registered state only.
  - Simultaneous push and pop leaves the count unchanged and both pointers advance.
  - A push while full is impossible: `req_ready` is 0.
- **FSM states:** IDLE, ISSUE, WAIT_DONE, ABORT.
- **IDLE**
  - `command = 0`.
  - If the FIFO is non-empty and `ready == 1`: pop the head entry, register `address`/`data`, set `command` to CMD_READ or CMD_WRITE from `rw`, clear the timer, and go to ISSUE.
  - If `ready == 0` in IDLE, wait; the master is still busy.
- **ISSUE**
  - Hold `command`, `address` and `data` stable.
  - When `ready == 0` (the master has accepted): `command <= 0`, clear the timer, go to WAIT_DONE.
- **WAIT_DONE**
  - `command = 0`; `address`/`data` stay held.
  - When `ready == 1`: pulse `done`, go to IDLE.
- **Timeout**
  - In ISSUE and WAIT_DONE the timer increments every cycle.
  - When the timer equals TIMEOUT, go to ABORT instead of staying in the state.
  - Timer width is $clog2(TIMEOUT+1); it never wraps.
- **ABORT**
  - `command <= 0`, pulse `err`, discard the transaction, go to IDLE in the next cycle.
  - The FIFO contents are kept.
- **Simultaneous events**
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins: no `err`.
  - `done` and `err` are never asserted together.
- **Reset (`rst` low), asynchronously, including mid-transaction**
  - FSM = IDLE, FIFO emptied (pointers and count 0), timer 0.
  - Outputs: `command` 0, `address` 0, `data` 0, `busy` 0, `done` 0, `err` 0, `fifo_count` 0, `req_ready` 1.

## Timing
- All outputs are registered except `req_ready`, which is decoded from registered `fifo_count`.
- **Latency:** a push at edge N into an empty FIFO with the FSM in IDLE and `ready` high gives a non-zero `command` after edge N+1.
- **Command hold:** `command` stays non-zero from its first cycle until the edge after `ready` is sampled low; minimum 1 cycle, maximum TIMEOUT+1 cycles.
- **`done` timing:** `done` is asserted the cycle after `ready` is sampled high in WAIT_DONE. The next transaction can issue at the earliest 1 cycle after `done`.
- **`err` timing:** `err` is asserted 1 cycle after the timer reaches TIMEOUT.
- **Throughput:** at most one transaction per (master busy time + 3) cycles.

## Test plan
- **Reset values:** hold `rst` low for 3 cycles with `req_valid` toggling -> all outputs at their reset values, `fifo_count` stays 0, no push recorded.
- **Single write:** push rw=0, addr=8'hAA, data=8'h5C; model master drops `ready` 2 cycles after `command`, raises it 20 cycles later -> `command` = 1 for exactly 3 cycles, starting 2 cycles after the push edge; `address` = AA, `data` = 5C; one `done` pulse; `busy` then falls.
- **Burst and full FIFO:** push 5 requests back-to-back while `ready` is held 0 -> `req_ready` drops after 4 pushes (`fifo_count` = 4). Release `ready` -> 4 transactions in order, 4 `done` pulses, then the 5th can be pushed.
- **Simultaneous push/pop at full:** with 4 queued, push on the same edge the FSM pops -> push blocked that cycle, `fifo_count` = 3, the push is accepted next cycle; pointer wrap is verified by data order.
- **Accept timeout:** TIMEOUT=15, `ready` stuck at 1 -> `command` non-zero for 16 cycles, `err` pulses once, `command` returns to 0, the next FIFO entry issues.
- **Reset mid-transaction:** assert `rst` while in WAIT_DONE with 2 entries queued -> `command`, `busy` and `fifo_count` go to 0 immediately (asynchronously), no `done`/`err` after release.

Source files
------------

// File: rtl/i2c_cmd_seq.sv
// Byte-transfer command sequencer in front of an I2C master: queues host requests
// and feeds them to the master one at a time, aborting a transaction that stalls.
module i2c_cmd_seq #(
   parameter int         DEPTH     = 4,
   parameter int         TIMEOUT   = 1023,
   parameter logic [3:0] CMD_WRITE = 4'd1,
   parameter logic [3:0] CMD_READ  = 4'd2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_rw,
   input  logic [7:0]             req_addr,
   input  logic [7:0]             req_data,
   output logic [3:0]             command,
   output logic [7:0]             address,
   output logic [7:0]             data,
   input  logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      ABORT     = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [3:0]       command_q, command_d;
   logic [7:0]       address_q, address_d;
   logic [7:0]       data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   // Entry layout: {rw, addr, data}
   logic [16:0]      fifo_mem [DEPTH];
   logic [16:0]      head;
   logic             push;
   logic             pop;
   logic             fifo_empty;

   assign req_ready  = (count_q != FULL_CNT);
   assign fifo_empty = (count_q == '0);
   assign push       = req_valid & req_ready;
   assign head       = fifo_mem[rd_ptr_q];

   // Storage carries no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {req_rw, req_addr, req_data};
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      command_d = command_q;
      address_d = address_q;
      data_d    = data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      pop       = 1'b0;

      case (state_q)
         IDLE: begin
            command_d = 4'd0;
            if (!fifo_empty && ready) begin
               pop       = 1'b1;
               address_d = head[15:8];
               data_d    = head[7:0];
               command_d = head[16] ? CMD_READ : CMD_WRITE;
               timer_d   = '0;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            // Acceptance is checked before the timeout so a late accept still completes.
            if (!ready) begin
               command_d = 4'd0;
               timer_d   = '0;
               state_d   = WAIT_DONE;
            end else if (timer_q == TMR_MAX) begin
               command_d = 4'd0;
               err_d     = 1'b1;
               state_d   = ABORT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            command_d = 4'd0;
            if (ready) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (timer_q == TMR_MAX) begin
               err_d   = 1'b1;
               state_d = ABORT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ABORT: begin
            command_d = 4'd0;
            timer_d   = '0;
            state_d   = IDLE;
         end
         default: begin
            command_d = 4'd0;
            timer_d   = '0;
            state_d   = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         timer_q   <= '0;
         command_q <= 4'd0;
         address_q <= 8'd0;
         data_q    <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         timer_q   <= timer_d;
         command_q <= command_d;
         address_q <= address_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign command    = command_q;
   assign address    = address_q;
   assign data       = data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Directed bench for i2c_cmd_seq: cycle table for single transfers plus
// hand-written sequences for full FIFO, timeout and asynchronous reset.
module tb_i2c_cmd_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       req_valid = 1'b0;
   logic       req_rw = 1'b0;
   logic [7:0] req_addr = 8'd0;
   logic [7:0] req_data = 8'd0;
   logic       ready = 1'b1;
   logic       req_ready;
   logic [3:0] command;
   logic [7:0] address;
   logic [7:0] data;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] fifo_count;

   logic       t_req_valid = 1'b0;
   logic       t_req_rw = 1'b0;
   logic [7:0] t_req_addr = 8'd0;
   logic [7:0] t_req_data = 8'd0;
   logic       t_ready = 1'b1;
   logic       t_req_ready;
   logic [3:0] t_command;
   logic [7:0] t_address;
   logic [7:0] t_data;
   logic       t_busy;
   logic       t_done;
   logic       t_err;
   logic [2:0] t_fifo_count;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   i2c_cmd_seq dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rw     (req_rw),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .command    (command),
      .address    (address),
      .data       (data),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .fifo_count (fifo_count)
   );

   i2c_cmd_seq #(.TIMEOUT(15)) dut_to (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (t_req_valid),
      .req_ready  (t_req_ready),
      .req_rw     (t_req_rw),
      .req_addr   (t_req_addr),
      .req_data   (t_req_data),
      .command    (t_command),
      .address    (t_address),
      .data       (t_data),
      .ready      (t_ready),
      .busy       (t_busy),
      .done       (t_done),
      .err        (t_err),
      .fifo_count (t_fifo_count)
   );

   typedef struct {
      logic       vld;
      logic       rw;
      logic [7:0] addr;
      logic [7:0] dat;
      logic       rdy;
      logic [3:0] e_cmd;
      logic [7:0] e_addr;
      logic [7:0] e_data;
      logic       e_busy;
      logic       e_done;
      logic       e_err;
      logic [2:0] e_cnt;
      logic       e_rdy;
   } vec_t;

   vec_t vecs[$];

   typedef struct {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] dat;
   } ent_t;

   ent_t burst[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act !== want) begin
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end else begin
         n_pass++;
      end
   endtask

   task automatic add_vec(input logic vld, input logic rw, input logic [7:0] addr,
                          input logic [7:0] dat, input logic rdy, input logic [3:0] e_cmd,
                          input logic [7:0] e_addr, input logic [7:0] e_data, input logic e_busy,
                          input logic e_done, input logic [2:0] e_cnt);
      vec_t v;
      v.vld = vld; v.rw = rw; v.addr = addr; v.dat = dat; v.rdy = rdy;
      v.e_cmd = e_cmd; v.e_addr = e_addr; v.e_data = e_data; v.e_busy = e_busy;
      v.e_done = e_done; v.e_err = 1'b0; v.e_cnt = e_cnt; v.e_rdy = (e_cnt != 3'd4);
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] outs();
      return {5'd0, command, address, data, busy, done, err, fifo_count, req_ready};
   endfunction

   initial begin
      int run1;
      int gap;
      int errs;
      int dones;
      bit seen1;
      bit seen2;
      logic [3:0] cmd2;

      // Single write (master accepts 2 cycles after command, busy 20 cycles), then a short read.
      add_vec(1, 0, 8'hAA, 8'h5C, 1, 4'd0, 8'h00, 8'h00, 0, 0, 3'd1);
      add_vec(0, 0, 8'h00, 8'h00, 1, 4'd1, 8'hAA, 8'h5C, 1, 0, 3'd0);
      add_vec(0, 0, 8'h00, 8'h00, 1, 4'd1, 8'hAA, 8'h5C, 1, 0, 3'd0);
      add_vec(0, 0, 8'h00, 8'h00, 1, 4'd1, 8'hAA, 8'h5C, 1, 0, 3'd0);
      for (int i = 0; i < 20; i++) begin
         add_vec(0, 0, 8'h00, 8'h00, 0, 4'd0, 8'hAA, 8'h5C, 1, 0, 3'd0);
      end
      add_vec(0, 0, 8'h00, 8'h00, 1, 4'd0, 8'hAA, 8'h5C, 0, 1, 3'd0);
      add_vec(0, 0, 8'h00, 8'h00, 1, 4'd0, 8'hAA, 8'h5C, 0, 0, 3'd0);
      add_vec(1, 1, 8'h3C, 8'h77, 1, 4'd0, 8'hAA, 8'h5C, 0, 0, 3'd1);
      add_vec(0, 0, 8'h00, 8'h00, 1, 4'd2, 8'h3C, 8'h77, 1, 0, 3'd0);
      add_vec(0, 0, 8'h00, 8'h00, 0, 4'd0, 8'h3C, 8'h77, 1, 0, 3'd0);
      add_vec(0, 0, 8'h00, 8'h00, 0, 4'd0, 8'h3C, 8'h77, 1, 0, 3'd0);
      add_vec(0, 0, 8'h00, 8'h00, 1, 4'd0, 8'h3C, 8'h77, 0, 1, 3'd0);
      add_vec(0, 0, 8'h00, 8'h00, 1, 4'd0, 8'h3C, 8'h77, 0, 0, 3'd0);

      burst[0] = '{1'b0, 8'h10, 8'hA1};
      burst[1] = '{1'b1, 8'h22, 8'hB2};
      burst[2] = '{1'b0, 8'h34, 8'hC3};
      burst[3] = '{1'b1, 8'h46, 8'hD4};
      burst[4] = '{1'b0, 8'h58, 8'hE5};

      // Reset held for 3 cycles while the host strobes requests.
      for (int c = 0; c < 3; c++) begin
         req_valid = ~req_valid;
         req_addr  = 8'h11 + 8'(c);
         @(posedge clk); #1;
         chk($sformatf("reset_outs_c%0d", c), outs(), {5'd0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
         chk($sformatf("reset_to_cnt_c%0d", c), {29'd0, t_fifo_count}, 32'd0);
      end
      req_valid = 1'b0;
      #3 rst = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_cnt", {29'd0, fifo_count}, 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         req_valid = vecs[i].vld;
         req_rw    = vecs[i].rw;
         req_addr  = vecs[i].addr;
         req_data  = vecs[i].dat;
         ready     = vecs[i].rdy;
         @(posedge clk); #1;
         chk($sformatf("vec%0d", i), outs(),
             {5'd0, vecs[i].e_cmd, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_busy,
              vecs[i].e_done, vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_rdy});
      end

      // Burst of 4 with the master busy, then a 5th offered against a full FIFO.
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_rw    = burst[i].rw;
         req_addr  = burst[i].addr;
         req_data  = burst[i].dat;
         @(posedge clk); #1;
         chk($sformatf("burst_cnt%0d", i), {29'd0, fifo_count}, 32'(i + 1));
      end
      chk("full_req_ready", {31'd0, req_ready}, 32'd0);
      chk("full_no_issue", {27'd0, busy, command}, 32'd0);
      req_rw   = burst[4].rw;
      req_addr = burst[4].addr;
      req_data = burst[4].dat;
      @(posedge clk); #1;
      chk("full_push_blocked", {29'd0, fifo_count}, 32'd4);

      // Master frees up while the 5th is still offered: pop wins, push lands a cycle later.
      ready = 1'b1;
      @(posedge clk); #1;
      chk("pop_at_full_cnt", {29'd0, fifo_count}, 32'd3);
      chk("pop_at_full_rdy", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      chk("late_push_cnt", {29'd0, fifo_count}, 32'd4);
      req_valid = 1'b0;

      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 20 && command == 4'd0; c++) begin
            @(posedge clk); #1;
         end
         chk($sformatf("burst_issue%0d", k), {12'd0, command, address, data},
             {12'd0, (burst[k].rw ? 4'd2 : 4'd1), burst[k].addr, burst[k].dat});
         ready = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("burst_accept%0d", k), {28'd0, command}, 32'd0);
         repeat (3) @(posedge clk);
         #1 ready = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("burst_done%0d", k), {30'd0, done, err}, 32'd2);
      end
      chk("burst_drained", {28'd0, busy, fifo_count}, 32'd0);

      // Accept timeout on the TIMEOUT=15 instance; its master never drops ready.
      t_req_valid = 1'b1;
      t_req_rw    = 1'b0;
      t_req_addr  = 8'h61;
      t_req_data  = 8'h99;
      @(posedge clk); #1;
      t_req_rw   = 1'b1;
      t_req_addr = 8'h62;
      t_req_data = 8'h42;
      run1 = 0; gap = 0; errs = 0; dones = 0; seen1 = 0; seen2 = 0; cmd2 = 4'd0;
      for (int c = 0; c < 80 && !seen2; c++) begin
         @(posedge clk); #1;
         t_req_valid = 1'b0;
         if (t_err) errs++;
         if (t_done) dones++;
         if (t_command != 4'd0 && t_address == 8'h61) begin
            run1++;
            seen1 = 1'b1;
         end else if (t_command != 4'd0 && t_address == 8'h62) begin
            seen2 = 1'b1;
            cmd2  = t_command;
         end else if (seen1 && t_command == 4'd0) begin
            gap++;
         end
      end
      chk("to_cmd_cycles", 32'(run1), 32'd16);
      chk("to_err_pulses", 32'(errs), 32'd1);
      chk("to_no_done", 32'(dones), 32'd0);
      chk("to_gap", 32'(gap), 32'd2);
      chk("to_next_issue", {27'd0, seen2, cmd2}, {27'd0, 1'b1, 4'd2});

      // Reset while waiting for the master, with two entries still queued.
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_rw    = 1'b0;
         req_addr  = 8'h70 + 8'(i);
         req_data  = 8'h80 + 8'(i);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      ready = 1'b0;
      @(posedge clk); #1;
      chk("mid_wait_state", {20'd0, busy, address, fifo_count}, {20'd0, 1'b1, 8'h70, 3'd2});
      #3 rst = 1'b0;
      #1;
      chk("async_reset_outs", outs(), {5'd0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
      #2 rst = 1'b1;
      ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         chk($sformatf("after_reset_quiet%0d", c), {25'd0, busy, done, err, command}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
